// File: rtl/morse_key_sequencer.sv
// Straight-key Morse decoder: classifies presses into dots/dashes by length and
// groups them into letters of up to five elements separated by a long release.
module morse_key_sequencer #(
    parameter int unsigned DASH_MIN = 20000000,
    parameter int unsigned GAP_MIN  = 60000000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       key,
    input  logic       clear,
    output logic       symbol_valid,
    output logic       symbol_is_dash,
    output logic       letter_valid,
    output logic [4:0] letter_code,
    output logic [2:0] letter_len,
    output logic       overflow,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        GAP,
        DISCARD
    } state_e;

    localparam logic [2:0] MaxLen = 3'd5;

    state_e      state_q, state_d;
    logic        run_q;
    logic        key_q;
    logic [31:0] press_cnt_q, press_cnt_d;
    logic [31:0] gap_cnt_q, gap_cnt_d;
    logic [2:0]  len_q, len_d;
    logic [4:0]  code_q, code_d;

    logic        symbol_valid_q, symbol_valid_d;
    logic        symbol_is_dash_q, symbol_is_dash_d;
    logic        letter_valid_q, letter_valid_d;
    logic        overflow_q, overflow_d;
    logic [4:0]  letter_code_q;
    logic [2:0]  letter_len_q;

    logic        key_rise;
    logic        is_dash;
    logic        letter_full;
    logic [31:0] gap_inc;
    logic        gap_done;

    assign key_rise    = key & ~key_q;
    assign is_dash     = (press_cnt_q >= DASH_MIN);
    assign letter_full = (len_q >= MaxLen);
    assign gap_inc     = gap_cnt_q + 32'd1;
    assign gap_done    = (gap_inc >= GAP_MIN);

    // run_q stays low for the first edge after reset so that key_q captures the
    // current level before any edge detection; a key held across reset is ignored.
    // NOTE: sequential state is updated only with non-blocking assignments so every
    // flop samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run_q <= 1'b0;
            key_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
            key_q <= key;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            press_cnt_q <= '0;
            gap_cnt_q   <= '0;
            len_q       <= '0;
            code_q      <= '0;
        end else begin
            state_q     <= state_d;
            press_cnt_q <= press_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            len_q       <= len_d;
            code_q      <= code_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        press_cnt_d = press_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        len_d       = len_q;
        code_d      = code_q;

        if (run_q) begin
            if (clear) begin
                state_d     = IDLE;
                press_cnt_d = '0;
                gap_cnt_d   = '0;
                len_d       = '0;
                code_d      = '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (key_rise) begin
                            state_d     = PRESS;
                            press_cnt_d = 32'd1;
                        end
                    end
                    PRESS: begin
                        if (key) begin
                            if (!is_dash) begin
                                press_cnt_d = press_cnt_q + 32'd1;
                            end
                        end else if (letter_full) begin
                            state_d   = DISCARD;
                            gap_cnt_d = 32'd1;
                            len_d     = '0;
                            code_d    = '0;
                        end else begin
                            state_d   = GAP;
                            gap_cnt_d = 32'd1;
                            len_d     = len_q + 3'd1;
                            code_d    = code_q | (5'(is_dash) << len_q);
                        end
                    end
                    GAP: begin
                        if (key) begin
                            if (key_rise) begin
                                state_d     = PRESS;
                                press_cnt_d = 32'd1;
                            end
                        end else if (gap_done) begin
                            state_d   = IDLE;
                            gap_cnt_d = '0;
                            len_d     = '0;
                            code_d    = '0;
                        end else begin
                            gap_cnt_d = gap_inc;
                        end
                    end
                    DISCARD: begin
                        if (key) begin
                            gap_cnt_d = '0;
                        end else if (gap_done) begin
                            state_d   = IDLE;
                            gap_cnt_d = '0;
                        end else begin
                            gap_cnt_d = gap_inc;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // Pulse decode: a release or a completed gap in this cycle becomes a
    // registered pulse next cycle; clear suppresses all of them.
    always_comb begin
        symbol_valid_d   = 1'b0;
        symbol_is_dash_d = 1'b0;
        overflow_d       = 1'b0;
        letter_valid_d   = 1'b0;
        if (run_q && !clear) begin
            if (state_q == PRESS && !key) begin
                symbol_valid_d   = 1'b1;
                symbol_is_dash_d = is_dash;
                overflow_d       = letter_full;
            end
            if (state_q == GAP && !key && gap_done) begin
                letter_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            symbol_valid_q   <= 1'b0;
            symbol_is_dash_q <= 1'b0;
            letter_valid_q   <= 1'b0;
            overflow_q       <= 1'b0;
            letter_code_q    <= '0;
            letter_len_q     <= '0;
        end else begin
            symbol_valid_q   <= symbol_valid_d;
            symbol_is_dash_q <= symbol_is_dash_d;
            letter_valid_q   <= letter_valid_d;
            overflow_q       <= overflow_d;
            if (letter_valid_d) begin
                letter_code_q <= code_q;
                letter_len_q  <= len_q;
            end
        end
    end

    assign symbol_valid   = symbol_valid_q;
    assign symbol_is_dash = symbol_is_dash_q;
    assign letter_valid   = letter_valid_q;
    assign overflow       = overflow_q;
    assign letter_code    = letter_code_q;
    assign letter_len     = letter_len_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Bench for morse_key_sequencer with short timing constants: a cycle table, directed
// corner sequences, and random keying against a letter-level reference model.
module tb_morse_key_sequencer;

    localparam int DASH_MIN = 4;
    localparam int GAP_MIN  = 8;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       key;
    logic       clear;
    logic       symbol_valid;
    logic       symbol_is_dash;
    logic       letter_valid;
    logic [4:0] letter_code;
    logic [2:0] letter_len;
    logic       overflow;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    morse_key_sequencer #(
        .DASH_MIN(DASH_MIN),
        .GAP_MIN (GAP_MIN)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .key           (key),
        .clear         (clear),
        .symbol_valid  (symbol_valid),
        .symbol_is_dash(symbol_is_dash),
        .letter_valid  (letter_valid),
        .letter_code   (letter_code),
        .letter_len    (letter_len),
        .overflow      (overflow),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       k;
        logic       c;
        logic       sv;
        logic       dash;
        logic       lv;
        logic [4:0] code;
        logic [2:0] len;
        logic       ov;
        logic       bsy;
    } vec_t;

    vec_t vecs[11];

    // Reference model: a letter is a list of elements; a press is timed as a run
    // length, and a letter ends after GAP_MIN consecutive low cycles.
    logic       m_hold;
    logic       m_kprev;
    logic       m_in_press;
    logic       m_discard;
    int         m_press_len;
    int         m_low_run;
    bit         m_elems[$];
    logic [4:0] m_lcode;
    logic [2:0] m_llen;
    logic       e_sv, e_dash, e_lv, e_ov;

    bit         sym_q[$];
    int         lv_cnt;
    int         ov_cnt;
    int         ov_at;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] pack(input logic sv, input logic dash, input logic lv,
                                         input logic [4:0] code, input logic [2:0] len,
                                         input logic ov, input logic bsy);
        return 32'({sv, sv & dash, lv, code, len, ov, bsy});
    endfunction

    function automatic logic [31:0] dut_outs();
        return pack(symbol_valid, symbol_is_dash, letter_valid, letter_code, letter_len,
                    overflow, busy);
    endfunction

    task automatic model_reset();
        m_hold      = 1'b1;
        m_kprev     = 1'b0;
        m_in_press  = 1'b0;
        m_discard   = 1'b0;
        m_press_len = 0;
        m_low_run   = 0;
        m_elems.delete();
        m_lcode     = '0;
        m_llen      = '0;
    endtask

    task automatic model_step(input logic k, input logic c);
        e_sv   = 1'b0;
        e_dash = 1'b0;
        e_lv   = 1'b0;
        e_ov   = 1'b0;
        if (m_hold) begin
            m_hold = 1'b0;
        end else if (c) begin
            m_in_press = 1'b0;
            m_discard  = 1'b0;
            m_elems.delete();
        end else if (m_in_press) begin
            if (k) begin
                m_press_len++;
            end else begin
                e_sv       = 1'b1;
                e_dash     = (m_press_len >= DASH_MIN);
                m_in_press = 1'b0;
                m_low_run  = 1;
                if (m_elems.size() == 5) begin
                    e_ov      = 1'b1;
                    m_discard = 1'b1;
                    m_elems.delete();
                end else begin
                    m_elems.push_back(e_dash);
                end
            end
        end else if (m_discard) begin
            if (k) begin
                m_low_run = 0;
            end else begin
                m_low_run++;
                if (m_low_run >= GAP_MIN) m_discard = 1'b0;
            end
        end else if (k && !m_kprev) begin
            m_in_press  = 1'b1;
            m_press_len = 1;
        end else if (!k && m_elems.size() != 0) begin
            m_low_run++;
            if (m_low_run >= GAP_MIN) begin
                e_lv    = 1'b1;
                m_llen  = 3'(m_elems.size());
                m_lcode = '0;
                foreach (m_elems[i]) if (m_elems[i]) m_lcode[i] = 1'b1;
                m_elems.delete();
            end
        end
        m_kprev = k;
    endtask

    function automatic logic [31:0] model_outs();
        return pack(e_sv, e_dash, e_lv, m_lcode, m_llen, e_ov,
                    m_in_press || m_discard || (m_elems.size() != 0));
    endfunction

    task automatic tick(input logic k, input logic c);
        key   = k;
        clear = c;
        @(posedge clock);
        #1;
        model_step(k, c);
        check($sformatf("cycle@%0t", $time), dut_outs(), model_outs());
        if (symbol_valid) sym_q.push_back(symbol_is_dash);
        if (letter_valid) lv_cnt++;
        if (overflow) begin
            ov_cnt++;
            ov_at = sym_q.size();
        end
    endtask

    task automatic press(input int n);
        repeat (n) tick(1'b1, 1'b0);
    endtask

    task automatic gap(input int n);
        repeat (n) tick(1'b0, 1'b0);
    endtask

    function automatic logic [31:0] sym_pattern();
        logic [2:0] pat;
        pat = '0;
        foreach (sym_q[i]) if (i < 3) pat[i] = sym_q[i];
        return 32'(pat);
    endfunction

    task automatic clear_obs();
        sym_q.delete();
        lv_cnt = 0;
        ov_cnt = 0;
        ov_at  = 0;
    endtask

    initial begin
        // 2-cycle press then 8 low cycles, written out cycle by cycle.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b1};
        for (int i = 3; i < 9; i++)
            vecs[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 3'd1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd1, 1'b0, 1'b0};

        reset_n = 1'b0;
        key     = 1'b0;
        clear   = 1'b0;
        model_reset();
        clear_obs();
        #2;
        check("reset_outputs", dut_outs(), 32'd0);
        #10;
        reset_n = 1'b1;
        gap(3);

        for (int i = 0; i < 11; i++) begin
            tick(vecs[i].k, vecs[i].c);
            check($sformatf("vec%0d", i), dut_outs(),
                  pack(vecs[i].sv, vecs[i].dash, vecs[i].lv, vecs[i].code, vecs[i].len,
                       vecs[i].ov, vecs[i].bsy));
        end

        // Dash, dot, dash letter.
        clear_obs();
        press(5); gap(3); press(2); gap(3); press(6); gap(8);
        check("dsh_dot_dsh_count", 32'(sym_q.size()), 32'd3);
        check("dsh_dot_dsh_types", sym_pattern(), 32'd5);
        check("dsh_dot_dsh_letters", 32'(lv_cnt), 32'd1);
        check("dsh_dot_dsh_code", 32'(letter_code), 32'd5);
        check("dsh_dot_dsh_len", 32'(letter_len), 32'd3);

        // Six elements overflow and the letter is discarded.
        clear_obs();
        for (int i = 0; i < 6; i++) begin
            press(2);
            if (i < 5) gap(3);
        end
        gap(8);
        check("ovf_symbols", 32'(sym_q.size()), 32'd6);
        check("ovf_pulses", 32'(ov_cnt), 32'd1);
        check("ovf_on_sixth", 32'(ov_at), 32'd6);
        check("ovf_no_letter", 32'(lv_cnt), 32'd0);
        check("ovf_idle", 32'(busy), 32'd0);

        // Clear during the second press, key held through it.
        clear_obs();
        press(2); gap(3); press(2);
        sym_q.delete();
        tick(1'b1, 1'b1);
        press(3);
        gap(10);
        check("clr_no_symbol", 32'(sym_q.size()), 32'd0);
        check("clr_no_letter", 32'(lv_cnt), 32'd0);
        check("clr_code_kept", 32'(letter_code), 32'd5);
        check("clr_len_kept", 32'(letter_len), 32'd3);
        check("clr_idle", 32'(busy), 32'd0);

        // Release and clear in the same cycle.
        clear_obs();
        press(3);
        tick(1'b0, 1'b1);
        gap(3);
        check("rel_clr_no_symbol", 32'(sym_q.size()), 32'd0);

        // Asynchronous reset mid-press, key held across the release.
        press(2);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", dut_outs(), 32'd0);
        model_reset();
        #2;
        reset_n = 1'b1;
        press(4);
        check("held_key_ignored", 32'(busy), 32'd0);
        gap(2);
        clear_obs();
        press(5); gap(8);
        check("post_reset_symbols", 32'(sym_q.size()), 32'd1);
        check("post_reset_letters", 32'(lv_cnt), 32'd1);
        check("post_reset_code", 32'(letter_code), 32'd1);
        check("post_reset_len", 32'(letter_len), 32'd1);

        // Gap boundary: 7 low cycles merge, 8 split.
        clear_obs();
        press(2); gap(7); press(2); gap(8);
        check("gap7_letters", 32'(lv_cnt), 32'd1);
        check("gap7_len", 32'(letter_len), 32'd2);
        check("gap7_code", 32'(letter_code), 32'd0);
        clear_obs();
        press(2); gap(8); press(5); gap(8);
        check("gap8_letters", 32'(lv_cnt), 32'd2);
        check("gap8_len", 32'(letter_len), 32'd1);
        check("gap8_code", 32'(letter_code), 32'd1);

        // Random keying with occasional clears.
        for (int seg = 0; seg < 300; seg++) begin
            int unsigned hi;
            int unsigned lo;
            hi = $urandom_range(1, 7);
            lo = $urandom_range(1, 11);
            for (int j = 0; j < int'(hi); j++) tick(1'b1, $urandom_range(0, 39) == 0);
            for (int j = 0; j < int'(lo); j++) tick(1'b0, $urandom_range(0, 39) == 0);
        end
        gap(12);
        check("final_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
